// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port seen by dmem_arbiter.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface dmem_arbiter_if;
   logic        i_m0_req;
   logic [15:0] i_m0_addr;
   logic [31:0] i_m0_wdata;
   logic        i_m0_wren;
   logic [2:0]  i_m0_ctrl;
   logic        i_m0_lock;
   logic        o_m0_gnt;
   logic        o_m0_rvalid;
   logic [31:0] o_m0_rdata;

   logic        i_m1_req;
   logic [15:0] i_m1_addr;
   logic [31:0] i_m1_wdata;
   logic        i_m1_wren;
   logic [2:0]  i_m1_ctrl;
   logic        i_m1_lock;
   logic        o_m1_gnt;
   logic        o_m1_rvalid;
   logic [31:0] o_m1_rdata;

   logic [15:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_mem_wren;
   logic [2:0]  o_mem_ctrl;
   logic [31:0] i_mem_rdata;
   logic [1:0]  o_owner;

   modport slave (
      input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_ctrl, i_m0_lock,
      output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_ctrl, i_m1_lock,
      output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      output o_mem_addr, o_mem_wdata, o_mem_wren, o_mem_ctrl, o_owner,
      input  i_mem_rdata
   );

   modport master (
      output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_ctrl, i_m0_lock,
      input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_ctrl, i_m1_lock,
      input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      input  o_mem_addr, o_mem_wdata, o_mem_wren, o_mem_ctrl, o_owner,
      output i_mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (m0) and a debug/DMA
// master (m1), with bounded lock ownership and one-cycle registered read return.
module dmem_arbiter #(
   parameter int LOCK_MAX = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [7:0] LCNT_LAST = 8'(LOCK_MAX - 1);

   state_t      state;
   logic        prio;
   logic [7:0]  lcnt;
   logic        gnt0;
   logic        gnt1;
   logic        gnt_lock;
   logic        m0_rvld_p1;
   logic        m1_rvld_p1;
   logic [31:0] m0_rdata_p1;
   logic [31:0] m1_rdata_p1;

   // Stage p0: combinational grant and memory request mux
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_m0_req && bus.i_m1_req) begin
               gnt0 = ~prio;
               gnt1 = prio;
            end else begin
               gnt0 = bus.i_m0_req;
               gnt1 = bus.i_m1_req;
            end
         end
         OWN0:    gnt0 = bus.i_m0_req;
         OWN1:    gnt1 = bus.i_m1_req;
         default: ;
      endcase
      if (i_rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      bus.o_mem_addr  = 16'h0000;
      bus.o_mem_wdata = 32'h0000_0000;
      bus.o_mem_wren  = 1'b0;
      bus.o_mem_ctrl  = 3'b010;
      gnt_lock        = 1'b0;
      if (gnt0) begin
         bus.o_mem_addr  = bus.i_m0_addr;
         bus.o_mem_wdata = bus.i_m0_wdata;
         bus.o_mem_wren  = bus.i_m0_wren;
         bus.o_mem_ctrl  = bus.i_m0_ctrl;
         gnt_lock        = bus.i_m0_lock;
      end else if (gnt1) begin
         bus.o_mem_addr  = bus.i_m1_addr;
         bus.o_mem_wdata = bus.i_m1_wdata;
         bus.o_mem_wren  = bus.i_m1_wren;
         bus.o_mem_ctrl  = bus.i_m1_ctrl;
         gnt_lock        = bus.i_m1_lock;
      end
   end

   assign bus.o_m0_gnt = gnt0;
   assign bus.o_m1_gnt = gnt1;

   // Stage p1: ownership FSM, round-robin pointer and registered read return
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         prio        <= 1'b0;
         lcnt        <= 8'd0;
         m0_rvld_p1  <= 1'b0;
         m1_rvld_p1  <= 1'b0;
         m0_rdata_p1 <= 32'h0000_0000;
         m1_rdata_p1 <= 32'h0000_0000;
      end else begin
         m0_rvld_p1 <= gnt0 && !bus.i_m0_wren;
         m1_rvld_p1 <= gnt1 && !bus.i_m1_wren;
         if (gnt0 && !bus.i_m0_wren) m0_rdata_p1 <= bus.i_mem_rdata;
         if (gnt1 && !bus.i_m1_wren) m1_rdata_p1 <= bus.i_mem_rdata;

         if (gnt0 || gnt1) begin
            // A forced release leaves prio pointing at the other master, so it wins next.
            prio <= gnt0;
            if (gnt_lock && (lcnt < LCNT_LAST)) begin
               state <= gnt0 ? OWN0 : OWN1;
               lcnt  <= lcnt + 8'd1;
            end else begin
               state <= IDLE;
               lcnt  <= 8'd0;
            end
         end else if (state != IDLE) begin
            state <= IDLE;
            lcnt  <= 8'd0;
         end
      end
   end

   assign bus.o_m0_rvalid = m0_rvld_p1;
   assign bus.o_m1_rvalid = m1_rvld_p1;
   assign bus.o_m0_rdata  = m0_rdata_p1;
   assign bus.o_m1_rdata  = m1_rdata_p1;
   assign bus.o_owner     = state;

endmodule
